// File: rtl/muldiv_unit_pkg.sv
// Shared pipeline definitions for the HI/LO multiply/divide unit:
// datapath width, ALU-control op codes and the sequencer state encoding.
package muldiv_unit_pkg;

  localparam int MD_DATA_W = 32;

  localparam logic [4:0] MD_MULT_OP  = 5'b00110;
  localparam logic [4:0] MD_MULTU_OP = 5'b00111;
  localparam logic [4:0] MD_DIV_OP   = 5'b01000;
  localparam logic [4:0] MD_DIVU_OP  = 5'b01001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage request / HI-LO result bundle between the pipeline and muldiv_unit.
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
);

  logic [4:0]        alu_ctrl_in;
  logic              start;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              flush;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output alu_ctrl_in, start, src_a, src_b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  alu_ctrl_in, start, src_a, src_b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Sign handling around the unsigned iteration core: operand magnitudes on the
// way in, two's-complement correction of product/quotient/remainder on the way out.
module muldiv_sign_fix
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic              is_signed_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  output logic [DATA_W-1:0] mag_a_o,
  output logic [DATA_W-1:0] mag_b_o,
  input  logic              is_div_i,
  input  logic              neg_main_i,
  input  logic              neg_rem_i,
  input  logic              div0_i,
  input  logic [DATA_W-1:0] raw_hi_i,
  input  logic [DATA_W-1:0] raw_lo_i,
  output logic [DATA_W-1:0] res_hi_o,
  output logic [DATA_W-1:0] res_lo_o
);

  logic [2*DATA_W-1:0] prod_fix;

  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  assign mag_a_o = (is_signed_i && src_a_i[DATA_W-1]) ? -src_a_i : src_a_i;
  assign mag_b_o = (is_signed_i && src_b_i[DATA_W-1]) ? -src_b_i : src_b_i;

  // Product negates as one 2*DATA_W value; quotient and remainder negate independently.
  always_comb begin
    prod_fix = {raw_hi_i, raw_lo_i};
    if (neg_main_i) prod_fix = -prod_fix;
    if (is_div_i) begin
      // Divide by zero: quotient forced to all-ones; remainder already holds |dividend|.
      res_lo_o = div0_i ? '1 : (neg_main_i ? -raw_lo_i : raw_lo_i);
      res_hi_o = neg_rem_i ? -raw_hi_i : raw_hi_i;
    end else begin
      res_hi_o = prod_fix[2*DATA_W-1:DATA_W];
      res_lo_o = prod_fix[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit. One bit per cycle: radix-2 shift-add
// multiply, restoring shift-subtract divide, DATA_W iterations per operation.
//
// state   | meaning
// ST_IDLE | accepts start or MTHI/MTLO writes
// ST_CALC | one iteration per cycle, down-counter reaches zero on the last
// ST_DONE | commits HI/LO (unless flushed); done is seen the following cycle
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int         DATA_W   = MD_DATA_W,
  parameter logic [4:0] MULT_OP  = MD_MULT_OP,
  parameter logic [4:0] MULTU_OP = MD_MULTU_OP,
  parameter logic [4:0] DIV_OP   = MD_DIV_OP,
  parameter logic [4:0] DIVU_OP  = MD_DIVU_OP
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  md_state_t         state_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] wrk_q;
  logic [DATA_W-1:0] dvs_q;
  logic              is_div_q;
  logic              neg_main_q;
  logic              neg_rem_q;
  logic              div0_q;

  logic              op_valid;
  logic              op_div;
  logic              op_signed;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   shl_rem;
  logic [DATA_W-1:0] rem_d;
  logic [DATA_W-1:0] wrk_d;

  assign op_div    = (bus.alu_ctrl_in == DIV_OP) || (bus.alu_ctrl_in == DIVU_OP);
  assign op_signed = (bus.alu_ctrl_in == MULT_OP) || (bus.alu_ctrl_in == DIV_OP);
  assign op_valid  = op_div || (bus.alu_ctrl_in == MULT_OP) || (bus.alu_ctrl_in == MULTU_OP);

  muldiv_sign_fix #(.DATA_W(DATA_W)) u_sign_fix (
    .is_signed_i (op_signed),
    .src_a_i     (bus.src_a),
    .src_b_i     (bus.src_b),
    .mag_a_o     (mag_a),
    .mag_b_o     (mag_b),
    .is_div_i    (is_div_q),
    .neg_main_i  (neg_main_q),
    .neg_rem_i   (neg_rem_q),
    .div0_i      (div0_q),
    .raw_hi_i    (rem_q),
    .raw_lo_i    (wrk_q),
    .res_hi_o    (res_hi),
    .res_lo_o    (res_lo)
  );

  // One iteration: rem_q is the upper half, wrk_q the multiplier / dividend-quotient half.
  always_comb begin
    add_sum = {1'b0, rem_q} + (wrk_q[0] ? {1'b0, dvs_q} : '0);
    shl_rem = {rem_q, wrk_q[DATA_W-1]};
    if (is_div_q) begin
      if (shl_rem >= {1'b0, dvs_q}) begin
        rem_d = DATA_W'(shl_rem - {1'b0, dvs_q});
        wrk_d = {wrk_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d = shl_rem[DATA_W-1:0];
        wrk_d = {wrk_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      rem_d = add_sum[DATA_W:1];
      wrk_d = {add_sum[0], wrk_q[DATA_W-1:1]};
    end
  end

  // Sequencer, work registers and architectural HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      wrk_q      <= '0;
      dvs_q      <= '0;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && op_valid && !bus.flush) begin
            state_q    <= ST_CALC;
            busy_q     <= 1'b1;
            cnt_q      <= CNT_W'(DATA_W - 1);
            rem_q      <= '0;
            wrk_q      <= mag_a;
            dvs_q      <= mag_b;
            is_div_q   <= op_div;
            neg_main_q <= op_signed && (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
            neg_rem_q  <= op_signed && bus.src_a[DATA_W-1];
            div0_q     <= op_div && (bus.src_b == '0);
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        ST_CALC: begin
          if (bus.flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            rem_q <= rem_d;
            wrk_q <= wrk_d;
            if (cnt_q == '0) state_q <= ST_DONE;
            else             cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (!bus.flush) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit with an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [4:0] C_MULT  = 5'b00110;
  localparam logic [4:0] C_MULTU = 5'b00111;
  localparam logic [4:0] C_DIV   = 5'b01000;
  localparam logic [4:0] C_DIVU  = 5'b01001;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_W(W)) bus ();

  muldiv_unit #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result as {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      C_MULT:  p = sa * sb;
      C_MULTU: p = {32'b0, a} * {32'b0, b};
      C_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      C_DIVU: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Launch one operation and follow it to completion; poke re-requests while busy.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    logic [63:0] exp;
    int nbusy, ndone;
    exp   = model(op, a, b);
    nbusy = 0;
    ndone = 0;
    bus.alu_ctrl_in = op;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
    bus.alu_ctrl_in = 5'b0;
    bus.src_a       = $urandom;
    bus.src_b       = $urandom;
    for (int i = 1; i <= W + 3; i++) begin
      nbusy += int'(bus.busy);
      ndone += int'(bus.done);
      if (i == W + 2) check({tag, " hi/lo"}, {bus.hi, bus.lo}, exp);
      if (poke && i == 5) begin
        bus.start       = 1'b1;
        bus.alu_ctrl_in = C_MULTU;
      end
      if (poke && i == 6) begin
        bus.start       = 1'b0;
        bus.alu_ctrl_in = 5'b0;
      end
      if (i < W + 3) tick();
    end
    check({tag, " busy cycles"}, 64'(nbusy), 64'(W + 1));
    check({tag, " done pulses"}, 64'(ndone), 64'd1);
  endtask

  initial begin
    logic [4:0]  ops [4];
    logic [4:0]  op;
    logic [31:0] a, b;
    ops[0] = C_MULT; ops[1] = C_MULTU; ops[2] = C_DIV; ops[3] = C_DIVU;

    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.alu_ctrl_in = 5'b0;
    bus.src_a       = '0;
    bus.src_b       = '0;
    bus.flush       = 1'b0;
    bus.hi_we       = 1'b0;
    bus.lo_we       = 1'b0;
    bus.wdata       = '0;
    repeat (2) tick();
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);

    // Start on the very first edge after reset release.
    rst = 1'b0;
    run_op("mult -1*2", C_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("mult -1*2 const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("multu ffffffff*2", C_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("multu const", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
    run_op("div -7/2", C_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div -7/2 const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu 100/0", C_DIVU, 32'd100, 32'd0, 1'b0);
    check("divu 100/0 const", {bus.hi, bus.lo}, 64'h0000_0064_FFFF_FFFF);
    run_op("div min/-1", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div min/-1 const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    run_op("div -7/0", C_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);
    check("div -7/0 const", {bus.hi, bus.lo}, 64'hFFFF_FFF9_FFFF_FFFF);
    run_op("start while busy", C_DIV, 32'd1000, 32'hFFFF_FFFD, 1'b1);

    for (int k = 0; k < 12; k++) begin
      op = ops[$urandom_range(0, 3)];
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op($sformatf("random %0d op %0d", k, op), op, a, b, 1'b0);
    end

    // Unrecognised code and start cancelled by flush are both ignored.
    bus.start       = 1'b1;
    bus.alu_ctrl_in = 5'b00000;
    tick();
    check("invalid op busy", 64'(bus.busy), 64'd0);
    bus.alu_ctrl_in = C_MULT;
    bus.flush       = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("idle flush cancels start", 64'(bus.busy), 64'd0);

    // MTHI / MTLO in idle.
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234_5678;
    tick();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h9ABC_DEF0;
    tick();
    bus.lo_we = 1'b0;
    check("mthi/mtlo", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);

    // Flush at iteration 10 with MTHI/MTLO attempted while busy.
    bus.alu_ctrl_in = C_MULTU;
    bus.src_a       = 32'hFFFF_FFFF;
    bus.src_b       = 32'hFFFF_FFFF;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) begin
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
      end
      if (i == 4) begin
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
      end
      tick();
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("calc flush busy", 64'(bus.busy), 64'd0);
    check("calc flush done", 64'(bus.done), 64'd0);
    check("calc flush hi/lo", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
    run_op("after flush", C_DIVU, 32'd1000, 32'd7, 1'b0);

    // Flush in the commit cycle suppresses the write and done.
    bus.alu_ctrl_in = C_MULT;
    bus.src_a       = 32'd3;
    bus.src_b       = 32'd5;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (W) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("done flush busy", 64'(bus.busy), 64'd0);
    check("done flush done", 64'(bus.done), 64'd0);
    check("done flush hi/lo", {bus.hi, bus.lo}, model(C_DIVU, 32'd1000, 32'd7));

    // Reset at iteration 5 of a divide takes effect immediately.
    bus.alu_ctrl_in = C_DIV;
    bus.src_a       = 32'hFFFF_FF9C;
    bus.src_b       = 32'd3;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("mid reset busy", 64'(bus.busy), 64'd0);
    check("mid reset hi/lo", {bus.hi, bus.lo}, 64'd0);
    tick();
    rst = 1'b0;

    // Start together with MTHI: operation runs, the write is dropped.
    bus.alu_ctrl_in = C_DIVU;
    bus.src_a       = 32'd50;
    bus.src_b       = 32'd7;
    bus.start       = 1'b1;
    bus.hi_we       = 1'b1;
    bus.wdata       = 32'hCAFE_F00D;
    tick();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    check("start+hi_we busy", 64'(bus.busy), 64'd1);
    check("start+hi_we hi kept", 64'(bus.hi), 64'd0);
    repeat (W + 1) tick();
    check("start+hi_we result", {bus.hi, bus.lo}, 64'h0000_0001_0000_0007);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/HI/LO width.
REQ-002 SHALL have parameter MULT_OP, default 5'b00110, signed multiply code.
REQ-003 SHALL have parameter MULTU_OP, default 5'b00111, unsigned multiply code.
REQ-004 SHALL have parameter DIV_OP, default 5'b01000, signed divide code.
REQ-005 SHALL have parameter DIVU_OP, default 5'b01001, unsigned divide code.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port alu_ctrl_in, input, 5, ALU control code from the EX stage.
REQ-009 SHALL have port start, input, 1, EX-stage mult/div request valid.
REQ-010 SHALL have port src_a / src_b, input, DATA_W each, rs / rt operands.
REQ-011 SHALL have port flush, input, 1, abort in-flight operation.
REQ-012 SHALL have port hi_we / lo_we, input, 1 each, MTHI / MTLO write strobes.
REQ-013 SHALL have port wdata, input, DATA_W, MTHI/MTLO data.
REQ-014 SHALL have port busy, output, 1, pipeline stall request.
REQ-015 SHALL have port done, output, 1, one-cycle result-committed pulse.
REQ-016 SHALL have port hi / lo, output, DATA_W each, architectural HI / LO registers.

Function
REQ-017 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-018 In IDLE, start=1 with alu_ctrl_in in {MULT,MULTU,DIV,DIVU} SHALL latch operands/op and enter CALC next cycle; other codes SHALL be ignored.
REQ-019 CALC SHALL run exactly DATA_W iterations (radix-2 shift-add for multiply, restoring shift-subtract for divide), then enter DONE.
REQ-020 DONE SHALL write HI/LO, assert done for that cycle, and return to IDLE; start at cycle T gives busy high T+1..T+DATA_W+1, hi/lo new at T+DATA_W+2.
REQ-021 busy SHALL equal (state != IDLE), registered, with no combinational path from start.
REQ-022 Multiply SHALL produce {HI,LO} = full 2*DATA_W product; signed forms via magnitude operation plus final two's-complement fix-up.
REQ-023 Divide SHALL produce LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
REQ-024 Divide by zero SHALL produce LO = all-ones, HI = dividend, same latency.
REQ-025 Signed 0x80000000 / -1 SHALL produce LO = 0x80000000, HI = 0.
REQ-026 start while busy SHALL be ignored.
REQ-027 flush in CALC or DONE SHALL return to IDLE next cycle, leave HI/LO unchanged and suppress done.
REQ-028 hi_we/lo_we SHALL write HI/LO only in IDLE; while busy they SHALL be ignored.
REQ-029 In IDLE, a valid start together with hi_we/lo_we SHALL start the operation and drop the write.
REQ-030 flush in IDLE SHALL also cancel a same-cycle start.

Reset
REQ-031 rst SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0 and clear the iteration counter and work registers, including mid-operation.
REQ-032 The first rising clk edge after rst deasserts SHALL accept a start.

Structure
REQ-033 Op codes, DATA_W and the FSM state encoding SHALL live in the shared pipeline package used by the ALU-control decoder.
REQ-034 Sign handling (abs-in, negate-out) SHALL be one sub-module, muldiv_sign_fix; the FSM and iteration datapath stay in muldiv_unit.

Verification
REQ-035 MULT, src_a=0xFFFFFFFF, src_b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE after 34 cycles, done pulsed once.
REQ-036 MULTU, src_a=0xFFFFFFFF, src_b=2 -> hi=0x00000001, lo=0xFFFFFFFE; busy high exactly 33 cycles.
REQ-037 DIV, src_a=-7, src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/0 -> lo=0xFFFFFFFF, hi=100.
REQ-038 Start MULTU, flush at iteration 10 -> busy low next cycle, no done, hi/lo keep prior values; a new start is accepted the following cycle.
REQ-039 Assert rst at iteration 5 of DIV -> hi=lo=0 and busy=0 immediately; start plus hi_we in IDLE -> op runs and HI is not written.
